// File: rtl/dsram_port_arbiter_pkg.sv
// Shared constants and helpers for the data-SRAM port arbiter.
// Build option DSRAM_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
package dsram_arb_pkg;

    localparam logic       PORT_M0  = 1'b0;
    localparam logic       PORT_M1  = 1'b1;
    localparam logic [3:0] WEN_READ = 4'b0000;

    // Bits needed to hold 0..max_wait in the starvation counter
    function automatic int cnt_w(input int max_wait);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= max_wait) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dsram_port_arbiter_if.sv
// Native SRAM-style requester port: request/address/write side plus grant and read return.
interface dsram_req_if #(parameter int AW = 16);

    logic          REQ;
    logic [AW-3:0] ADDR;
    logic [3:0]    WEN;
    logic [31:0]   WDATA;
    logic          GNT;
    logic          RVALID;
    logic [31:0]   RDATA;

    modport master (output REQ, ADDR, WEN, WDATA, input GNT, RVALID, RDATA);
    modport slave  (input REQ, ADDR, WEN, WDATA, output GNT, RVALID, RDATA);

endinterface

// File: rtl/dsram_port_arbiter_pick.sv
// Combinational grant selection for the two DSRAM requesters.
// DSRAM_ARB_RR_EN: round-robin tie-break; otherwise M0 priority with M1 starvation override.
module dsram_arb_pick
    import dsram_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CW       = 3
) (
    input  logic [1:0]    i_req,
    input  logic          i_rst_n,
`ifdef DSRAM_ARB_RR_EN
    input  logic          i_rr_ptr,
`else
    input  logic [CW-1:0] i_starv_cnt,
`endif
    output logic [1:0]    o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_rst_n) begin
`ifdef DSRAM_ARB_RR_EN
            // i_rr_ptr holds the last winner, so a tie goes to the other port
            if (i_req == 2'b11)
                o_gnt = (i_rr_ptr == PORT_M1) ? 2'b01 : 2'b10;
            else
                o_gnt = i_req;
`else
            if (i_req[1] && (i_starv_cnt == CW'(MAX_WAIT)))
                o_gnt = 2'b10;
            else if (i_req[0])
                o_gnt = 2'b01;
            else if (i_req[1])
                o_gnt = 2'b10;
`endif
        end
    end

endmodule

// File: rtl/dsram_port_arbiter.sv
// Two-port arbiter in front of the single-port data SRAM: grant, SRAM mux and read return.
// Build option DSRAM_ARB_RR_EN selects round-robin arbitration (no starvation counter).
module dsram_port_arbiter
    import dsram_arb_pkg::*;
#(
    parameter int AW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    dsram_req_if.slave    M0,
    dsram_req_if.slave    M1,
    output logic [AW-3:0] SRAMADDR,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS,
    input  logic [31:0]   SRAMRDATA
);

    localparam int CW = cnt_w(MAX_WAIT);

    logic [1:0] w_gnt;
    logic       w_rd_issue;
    logic       r_rvalid;
    logic       r_rd_owner;

`ifdef DSRAM_ARB_RR_EN
    logic r_rr_ptr;
`else
    logic [CW-1:0] r_starv_cnt;
`endif

    dsram_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .CW       (CW)
    ) u_pick (
        .i_req       ({M1.REQ, M0.REQ}),
        .i_rst_n     (HRESETn),
`ifdef DSRAM_ARB_RR_EN
        .i_rr_ptr    (r_rr_ptr),
`else
        .i_starv_cnt (r_starv_cnt),
`endif
        .o_gnt       (w_gnt)
    );

    assign M0.GNT = w_gnt[0];
    assign M1.GNT = w_gnt[1];
    assign SRAMCS = |w_gnt;

    always_comb begin
        SRAMADDR  = '0;
        SRAMWEN   = 4'b0000;
        SRAMWDATA = 32'h0;
        if (w_gnt[1]) begin
            SRAMADDR  = M1.ADDR;
            SRAMWEN   = M1.WEN;
            SRAMWDATA = M1.WDATA;
        end else if (w_gnt[0]) begin
            SRAMADDR  = M0.ADDR;
            SRAMWEN   = M0.WEN;
            SRAMWDATA = M0.WDATA;
        end
    end

    assign w_rd_issue = SRAMCS && (SRAMWEN == WEN_READ);

    // Only the latest grant matters: a write or idle cycle drops rvalid
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rvalid   <= 1'b0;
            r_rd_owner <= PORT_M0;
        end else begin
            r_rvalid <= w_rd_issue;
            if (w_rd_issue) r_rd_owner <= w_gnt[1] ? PORT_M1 : PORT_M0;
        end
    end

    assign M0.RVALID = r_rvalid && (r_rd_owner == PORT_M0);
    assign M1.RVALID = r_rvalid && (r_rd_owner == PORT_M1);
    assign M0.RDATA  = M0.RVALID ? SRAMRDATA : 32'h0;
    assign M1.RDATA  = M1.RVALID ? SRAMRDATA : 32'h0;

`ifdef DSRAM_ARB_RR_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_rr_ptr <= PORT_M1;
        else if (|w_gnt)
            r_rr_ptr <= w_gnt[1] ? PORT_M1 : PORT_M0;
    end
`else
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_starv_cnt <= '0;
        else if (!M1.REQ || w_gnt[1])
            r_starv_cnt <= '0;
        else if (r_starv_cnt != CW'(MAX_WAIT))
            r_starv_cnt <= r_starv_cnt + CW'(1);
    end
`endif

endmodule
